// File: rtl/gain_stereo_scheduler_pkg.sv
// gain_stereo_scheduler_pkg: shared types, constants and the dequantising shift.
// Defining GAIN_SAT_EN makes dequant_shift saturate instead of wrapping.
package gain_stereo_scheduler_pkg;
  typedef enum logic {LEFT, RIGHT} chan_t;
  typedef enum logic [1:0] {S_ARB, S_MUL, S_OUT} sched_state_t;
  localparam int BITS_DEFAULT = 10;
  localparam int VOL_DEFAULT = 1024;
  localparam int OUT_SCALE = 14;
  function automatic logic [31:0] dequant_shift(input logic signed [63:0] prod, input int bits);
    logic signed [63:0] s;
    s = (prod >>> bits) <<< (OUT_SCALE - bits);
`ifdef GAIN_SAT_EN
    if (s > 64'sh0000_0000_7fff_ffff) return 32'h7fff_ffff;
    if (s < -64'sh0000_0000_8000_0000) return 32'h8000_0000;
`endif
    return s[31:0];
  endfunction
endpackage

// File: rtl/gain_mul_stage.sv
// gain_mul_stage: sample latch, registered 32x32 signed multiply and dequantising shift.
// Saturation of the result follows GAIN_SAT_EN through dequant_shift.
module gain_mul_stage import gain_stereo_scheduler_pkg::*; #(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        mul,
  input  logic [31:0] din,
  input  logic [31:0] vol,
  output logic [31:0] result
);
  logic [31:0] sample_q, sample_d;
  logic signed [63:0] prod_q, prod_d;
  always_comb begin
    sample_d = load ? din : sample_q;
    prod_d = mul ? $signed(sample_q) * $signed(vol) : prod_q;
    result = dequant_shift(prod_q, BITS);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sample_q <= '0;
      prod_q <= '0;
    end else begin
      sample_q <= sample_d;
      prod_q <= prod_d;
    end
  end
endmodule

// File: rtl/gain_stereo_scheduler.sv
// gain_stereo_scheduler: shares one gain multiplier between L/R in strict alternation,
// applying volume changes only at pair boundaries. GAIN_SAT_EN enables output saturation.
module gain_stereo_scheduler import gain_stereo_scheduler_pkg::*; #(
  parameter int BITS = BITS_DEFAULT,
  parameter int VOL_DEFAULT = gain_stereo_scheduler_pkg::VOL_DEFAULT,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 left_rd_en,
  input  logic                 left_empty,
  input  logic [31:0]          left_dout,
  output logic                 right_rd_en,
  input  logic                 right_empty,
  input  logic [31:0]          right_dout,
  output logic                 left_out_wr_en,
  input  logic                 left_out_full,
  output logic [31:0]          left_out_din,
  output logic                 right_out_wr_en,
  input  logic                 right_out_full,
  output logic [31:0]          right_out_din,
  input  logic                 vol_wr_en,
  input  logic [31:0]          vol_din,
  output logic                 vol_pending,
  output logic [CNT_WIDTH-1:0] pair_count
);
  sched_state_t state_q, state_d;
  chan_t chan_q, chan_d;
  logic [31:0] vol_active_q, vol_active_d, vol_shadow_q, vol_shadow_d, result;
  logic vol_pending_q, vol_pending_d, rd, wr, apply, is_left;
  logic [CNT_WIDTH-1:0] pair_count_q, pair_count_d;
  always_comb begin
    is_left = chan_q == LEFT;
    rd = reset && state_q == S_ARB && !(is_left ? left_empty : right_empty);
    wr = state_q == S_OUT && !(is_left ? left_out_full : right_out_full);
    apply = state_q == S_ARB && is_left && vol_pending_q;
    state_d = rd ? S_MUL : state_q == S_MUL ? S_OUT : wr ? S_ARB : state_q;
    chan_d = wr ? (is_left ? RIGHT : LEFT) : chan_q;
    vol_active_d = apply ? vol_shadow_q : vol_active_q;
    vol_shadow_d = vol_wr_en ? vol_din : vol_shadow_q;
    // a write landing on the apply cycle keeps pending set for the next pair
    vol_pending_d = vol_wr_en | (vol_pending_q & ~apply);
    pair_count_d = pair_count_q + CNT_WIDTH'(wr && !is_left);
    left_rd_en = rd && is_left;
    right_rd_en = rd && !is_left;
    left_out_wr_en = wr && is_left;
    right_out_wr_en = wr && !is_left;
    left_out_din = left_out_wr_en ? result : '0;
    right_out_din = right_out_wr_en ? result : '0;
    vol_pending = vol_pending_q;
    pair_count = pair_count_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_ARB;
      chan_q <= LEFT;
      vol_active_q <= 32'(VOL_DEFAULT);
      vol_shadow_q <= 32'(VOL_DEFAULT);
      vol_pending_q <= 1'b0;
      pair_count_q <= '0;
    end else begin
      state_q <= state_d;
      chan_q <= chan_d;
      vol_active_q <= vol_active_d;
      vol_shadow_q <= vol_shadow_d;
      vol_pending_q <= vol_pending_d;
      pair_count_q <= pair_count_d;
    end
  end
  gain_mul_stage #(.BITS(BITS)) u_mul (
    .clock (clock),
    .reset (reset),
    .load  (rd),
    .mul   (state_q == S_MUL),
    .din   (is_left ? left_dout : right_dout),
    .vol   (vol_active_q),
    .result(result)
  );
endmodule

// File: tb/tb_gain_stereo_scheduler.sv
// tb_gain_stereo_scheduler: FIFO models, output scoreboard queues, table vectors
// and hand-written sequences for reset, alternation, backpressure, volume and wrap.
module tb_gain_stereo_scheduler;
  logic clock = 1'b0, reset = 1'b0;
  logic left_rd_en, right_rd_en, left_out_wr_en, right_out_wr_en, vol_pending;
  logic left_empty = 1'b1, right_empty = 1'b1, left_out_full = 1'b0, right_out_full = 1'b0;
  logic vol_wr_en = 1'b0;
  logic [31:0] left_dout = '0, right_dout = '0, vol_din = '0, left_out_din, right_out_din;
  logic [15:0] pair_count;
  logic [31:0] lq[$], rq[$], exp_l[$], exp_r[$];
  int n_cmp = 0, n_bad = 0, lrd = 0, rrd = 0, lwr = 0, rwr = 0, last_wr = 1;
  logic [15:0] exp_pc = '0;

  typedef struct {logic [31:0] l, r, el, er;} vec_t;
  vec_t vecs[6];

  gain_stereo_scheduler dut (
    .clock(clock), .reset(reset),
    .left_rd_en(left_rd_en), .left_empty(left_empty), .left_dout(left_dout),
    .right_rd_en(right_rd_en), .right_empty(right_empty), .right_dout(right_dout),
    .left_out_wr_en(left_out_wr_en), .left_out_full(left_out_full), .left_out_din(left_out_din),
    .right_out_wr_en(right_out_wr_en), .right_out_full(right_out_full), .right_out_din(right_out_din),
    .vol_wr_en(vol_wr_en), .vol_din(vol_din), .vol_pending(vol_pending), .pair_count(pair_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      chk("strobe_onehot_din_zero",
          {60'(int'(left_rd_en) + int'(right_rd_en) + int'(left_out_wr_en) + int'(right_out_wr_en) > 1),
           (!left_out_wr_en && left_out_din != 0), (!right_out_wr_en && right_out_din != 0)}, 64'd0);
    end
    if (left_rd_en) lrd++;
    if (right_rd_en) rrd++;
    if (left_out_wr_en) begin
      lwr++;
      chk("left_alternation", 64'(last_wr), 64'd1);
      last_wr = 0;
      if (exp_l.size() == 0) chk("left_unexpected_write", 64'(left_out_din), 64'hdead);
      else chk("left_out_din", 64'(left_out_din), 64'(exp_l.pop_front()));
    end
    if (right_out_wr_en) begin
      rwr++;
      chk("right_alternation", 64'(last_wr), 64'd0);
      last_wr = 1;
      if (exp_r.size() == 0) chk("right_unexpected_write", 64'(right_out_din), 64'hdead);
      else chk("right_out_din", 64'(right_out_din), 64'(exp_r.pop_front()));
    end
  end

  task automatic upd();
    left_empty = lq.size() == 0;
    right_empty = rq.size() == 0;
    left_dout = left_empty ? '0 : lq[0];
    right_dout = right_empty ? '0 : rq[0];
  endtask

  task automatic tick();
    logic pl, pr;
    @(negedge clock);
    pl = left_rd_en;
    pr = right_rd_en;
    @(posedge clock);
    #1;
    if (pl) void'(lq.pop_front());
    if (pr) void'(rq.pop_front());
    upd();
  endtask

  task automatic push_l(input logic [31:0] v, input logic [31:0] e);
    lq.push_back(v);
    exp_l.push_back(e);
    upd();
  endtask

  task automatic push_r(input logic [31:0] v, input logic [31:0] e);
    rq.push_back(v);
    exp_r.push_back(e);
    upd();
  endtask

  task automatic push_pair(input logic [31:0] l, r, el, er);
    push_l(l, el);
    push_r(r, er);
    exp_pc++;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_l.size() != 0 || exp_r.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    if (exp_l.size() != 0 || exp_r.size() != 0) begin
      chk({name, "_timeout"}, 64'(exp_l.size() + exp_r.size()), 64'd0);
      exp_l.delete();
      exp_r.delete();
    end
    repeat (2) tick();
  endtask

  task automatic wr_vol(input logic [31:0] v);
    vol_wr_en = 1'b1;
    vol_din = v;
    tick();
    vol_wr_en = 1'b0;
  endtask

  initial begin
    int s0, s1;
    vecs[0] = '{32'd100, -32'sd100, 32'd1600, -32'sd1600};
    vecs[1] = '{32'd0, 32'd0, 32'd0, 32'd0};
    vecs[2] = '{32'd1, -32'sd1, 32'd16, -32'sd16};
    vecs[3] = '{32'd7, 32'd3, 32'd112, 32'd48};
    vecs[4] = '{-32'sd5, 32'd1000, -32'sd80, 32'd16000};
    vecs[5] = '{32'd123456, -32'sd123456, 32'd1975296, -32'sd1975296};

    // reset held: a waiting sample must not be popped
    lq.push_back(32'd100);
    upd();
    repeat (2) tick();
    chk("reset_outputs", {left_rd_en, right_rd_en, left_out_wr_en, right_out_wr_en,
        vol_pending, pair_count, left_out_din[0 +: 8], right_out_din[0 +: 8]}, 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("reset_mid_mul_outputs", {left_rd_en, right_rd_en, left_out_wr_en, right_out_wr_en,
        vol_pending, pair_count, 1'b0}, 64'd0);
    chk("reset_mid_mul_din", {left_out_din, right_out_din}, 64'd0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    push_pair(vecs[0].l, vecs[0].r, vecs[0].el, vecs[0].er);
    drain("first_pair");
    chk("pair_count_first", 64'(pair_count), 64'(exp_pc));
    for (int i = 1; i < 6; i++) push_pair(vecs[i].l, vecs[i].r, vecs[i].el, vecs[i].er);
    drain("table");
    chk("pair_count_table", 64'(pair_count), 64'(exp_pc));

    // right has data, left empty: nothing may be read out of turn
    for (int i = 1; i <= 5; i++) push_r(32'(i * 10), 32'(i * 160));
    s0 = lrd + rrd;
    repeat (20) tick();
    chk("alt_no_read", 64'(lrd + rrd), 64'(s0));
    push_l(32'd8, 32'd128);
    for (int i = 1; i <= 4; i++) push_l(32'(i), 32'(i * 16));
    exp_pc += 5;
    drain("alternation");
    chk("pair_count_alt", 64'(pair_count), 64'(exp_pc));

    left_out_full = 1'b1;
    push_pair(32'd5, 32'd6, 32'd80, 32'd96);
    repeat (4) tick();
    s0 = lwr;
    s1 = rrd;
    repeat (10) tick();
    chk("bp_hold_no_write", 64'(lwr), 64'(s0));
    chk("bp_hold_no_read", 64'(rrd), 64'(s1));
    chk("bp_hold_din_zero", 64'(left_out_din), 64'd0);
    left_out_full = 1'b0;
    repeat (2) tick();
    chk("bp_one_write", 64'(lwr), 64'(s0 + 1));
    drain("backpressure");

    // volume written mid-pair only takes effect from the next pair
    s0 = lrd;
    push_l(32'd100, 32'd1600);
    for (int n = 0; n < 20 && lrd == s0; n++) tick();
    chk("vol_left_read_seen", 64'(lrd), 64'(s0 + 1));
    wr_vol(32'd512);
    chk("vol_pending_mid_pair", 64'(vol_pending), 64'd1);
    push_r(32'd100, 32'd1600);
    exp_pc++;
    repeat (3) tick();
    chk("vol_pending_in_between", 64'(vol_pending), 64'd1);
    drain("vol_old_pair");
    push_pair(32'd100, -32'sd100, 32'd800, -32'sd800);
    drain("vol_new_pair");
    chk("vol_pending_cleared", 64'(vol_pending), 64'd0);
    wr_vol(32'd300);
    wr_vol(32'd2048);
    chk("vol_pending_coincide", 64'(vol_pending), 64'd1);
    push_pair(32'd10, -32'sd10, 32'd320, -32'sd320);
    drain("vol_last_wins");

    wr_vol(32'd4096);
`ifdef GAIN_SAT_EN
    push_pair(32'h7fff_ffff, 32'h8000_0000, 32'h7fff_ffff, 32'h8000_0000);
`else
    push_pair(32'h7fff_ffff, 32'h8000_0000, 32'hffff_ffc0, 32'h0000_0000);
`endif
    drain("overflow");
    chk("pair_count_before_wrap", 64'(pair_count), 64'(exp_pc));

    wr_vol(32'd1024);
    force dut.pair_count_q = 16'hffff;
    tick();
    release dut.pair_count_q;
    tick();
    chk("pair_count_preload", 64'(pair_count), 64'hffff);
    exp_pc = 16'hffff;
    push_pair(32'd1, 32'd2, 32'd16, 32'd32);
    drain("wrap");
    chk("pair_count_wrap", 64'(pair_count), 64'(exp_pc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
